// File: rtl/bus_requester.sv
// -----------------------------------------------------------------------------
// bus_requester
//
// Purpose:
//   Requester side of the shared-bus grant protocol (req/gnt/done/dly).
//   A local command source hands over a beat count with a start strobe. The
//   block raises a request until the arbiter grants the bus, runs the data
//   beats against the target, pulses done on completion, and holds dly while
//   the target still needs post-transfer wait time. A missing grant (timeout),
//   a dropped grant mid-transfer, or a zero-length command raises a one-cycle
//   registered error pulse. Runs in the arbiter's clock domain.
//
// Parameters:
//   LEN_W    - width of the beat-count command and the beat counter
//   TIMEOUT  - cycles allowed in REQ without a grant before aborting (>= 2)
//
// Ports:
//   i_clk       - clock, rising edge
//   i_rst       - synchronous reset, active high
//   i_start     - command strobe, only honoured in IDLE
//   i_len       - beats to transfer, sampled with i_start
//   i_gnt       - bus grant from the arbiter
//   i_tgt_rdy   - target accepts a beat this cycle
//   i_tgt_hold  - target asks for post-transfer wait time
//   o_req       - bus request (REQ and XFER)
//   o_done      - transfer complete, one-cycle pulse (DONE)
//   o_dly       - post-transfer wait request (DONE/WAIT and i_tgt_hold)
//   o_busy      - FSM is not idle
//   o_beat      - a beat completes this cycle
//   o_beat_cnt  - beats completed in the current/last transfer
//   o_err       - one-cycle abort pulse (bad command, timeout, grant loss)
// -----------------------------------------------------------------------------
module bus_requester #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_gnt,
  input  logic             i_tgt_rdy,
  input  logic             i_tgt_hold,
  output logic             o_req,
  output logic             o_done,
  output logic             o_dly,
  output logic             o_busy,
  output logic             o_beat,
  output logic [LEN_W-1:0] o_beat_cnt,
  output logic             o_err
);

  // Timeout counter only ever needs to hold 0 .. TIMEOUT-1.
  localparam int unsigned        TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0]   LEN_ONE = LEN_W'(1);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StXfer = 3'd2,
    StDone = 3'd3,
    StWait = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e           r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_beat_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_err;

  // ---------------------------------------------------------------------------
  // Decoded conditions
  // ---------------------------------------------------------------------------
  state_e w_state_next;
  logic   w_in_idle;
  logic   w_in_req;
  logic   w_in_xfer;
  logic   w_cmd_ok;
  logic   w_cmd_bad;
  logic   w_timeout;
  logic   w_gnt_loss;
  logic   w_beat;
  logic   w_last_beat;
  logic   w_err_set;

  assign w_in_idle  = (r_state == StIdle);
  assign w_in_req   = (r_state == StReq);
  assign w_in_xfer  = (r_state == StXfer);

  assign w_cmd_ok   = w_in_idle & i_start & (i_len != '0);
  assign w_cmd_bad  = w_in_idle & i_start & (i_len == '0);

  // A grant arriving on the same edge as the timeout wins, hence the ~i_gnt.
  assign w_timeout  = w_in_req & ~i_gnt & (r_to_cnt == TO_LAST);
  assign w_gnt_loss = w_in_xfer & ~i_gnt;

  assign w_beat      = w_in_xfer & i_tgt_rdy & i_gnt;
  // r_len is never zero outside IDLE, so len-1 cannot underflow here.
  assign w_last_beat = w_beat & (r_beat_cnt == (r_len - LEN_ONE));

  assign w_err_set  = w_cmd_bad | w_timeout | w_gnt_loss;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_cmd_ok) begin
          w_state_next = StReq;
        end
      end
      StReq: begin
        if (i_gnt) begin
          w_state_next = StXfer;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_next = StIdle;
        end
      end
      StXfer: begin
        if (!i_gnt) begin
          w_state_next = StIdle;
        end else if (w_last_beat) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_state_next = i_tgt_hold ? StWait : StIdle;
      end
      StWait: begin
        if (!i_tgt_hold) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. req/done/busy are pure state decodes; dly and beat also
  // qualify with same-cycle inputs so the arbiter sees them without delay.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_req  = 1'b0;
    o_done = 1'b0;
    o_dly  = 1'b0;
    o_busy = 1'b1;
    unique case (r_state)
      StIdle: begin
        o_busy = 1'b0;
      end
      StReq: begin
        o_req = 1'b1;
      end
      StXfer: begin
        o_req = 1'b1;
      end
      StDone: begin
        o_done = 1'b1;
        o_dly  = i_tgt_hold;
      end
      StWait: begin
        o_dly = i_tgt_hold;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_beat     = w_beat;
  assign o_beat_cnt = r_beat_cnt;
  assign o_err      = r_err;

  // ---------------------------------------------------------------------------
  // Datapath: latched length, beat counter, grant timeout counter, error pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_to_cnt   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_err_set;

      if (w_cmd_ok) begin
        r_len      <= i_len;
        r_beat_cnt <= '0;
        r_to_cnt   <= '0;
      end

      // Stop at TO_LAST; the FSM leaves REQ on that cycle anyway.
      if (w_in_req && !i_gnt && (r_to_cnt != TO_LAST)) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      // Counter ends at len, so len = 2^LEN_W-1 never wraps.
      if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + LEN_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Structural sanity properties
  // ---------------------------------------------------------------------------
  a_done_no_req : assert property (@(posedge i_clk) disable iff (i_rst)
    o_done |-> !o_req);

  a_cnt_bounded : assert property (@(posedge i_clk) disable iff (i_rst)
    o_busy |-> (o_beat_cnt <= r_len));

  a_beat_in_xfer : assert property (@(posedge i_clk) disable iff (i_rst)
    o_beat |-> (o_req && i_gnt));

endmodule

// File: tb/tb_bus_requester.sv
module tb_bus_requester;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned TIMEOUT = 16;

  localparam int KSucc = 0;
  localparam int KTmo  = 1;
  localparam int KLoss = 2;
  localparam int KBad  = 3;
  localparam int KRst  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             gnt;
  logic             tgt_rdy;
  logic             tgt_hold;
  logic             req;
  logic             done;
  logic             dly;
  logic             busy;
  logic             beat;
  logic [LEN_W-1:0] beat_cnt;
  logic             err;

  always #5 clk = ~clk;

  bus_requester #(
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_len      (len),
    .i_gnt      (gnt),
    .i_tgt_rdy  (tgt_rdy),
    .i_tgt_hold (tgt_hold),
    .o_req      (req),
    .o_done     (done),
    .o_dly      (dly),
    .o_busy     (busy),
    .o_beat     (beat),
    .o_beat_cnt (beat_cnt),
    .o_err      (err)
  );

  // Expected outcome of one command; -1 in a count field means "not checked".
  typedef struct {
    int kind;
    int cnt;
    int n_req;
    int n_beat;
    int n_dly;
    int n_busy;
    int n_done;
    int done_off;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   last_cnt    = 0;
  bit   mon_en      = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic string kname(input int k);
    case (k)
      KSucc:   return "xfer";
      KTmo:    return "timeout";
      KLoss:   return "gnt_loss";
      KBad:    return "bad_cmd";
      default: return "reset";
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: accumulates per-transfer activity, pops and compares when the
  // requester returns to idle or raises an error from idle.
  // ---------------------------------------------------------------------------
  int   a_req, a_beat, a_dly, a_busy, a_done, a_off;
  bit   prev_busy = 1'b0;
  exp_t m_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) begin
        if (!prev_busy) begin
          a_req = 0; a_beat = 0; a_dly = 0; a_busy = 0; a_done = 0; a_off = -1;
        end
        if (done) begin
          a_done++;
          a_off = a_busy;
        end
        a_req  += int'(req);
        a_beat += int'(beat);
        a_dly  += int'(dly);
        a_busy++;
        if (err) check("err_while_busy", int'(err), 0);
      end else begin
        if (req || done || dly || beat) begin
          check("idle_outputs_quiet", int'({req, done, dly, beat}), 0);
        end
        if (prev_busy || err) begin
          if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 0, 1);
          end else begin
            m_e = exp_q.pop_front();
            if (!prev_busy) begin
              check("expected_bad_cmd_kind", KBad, m_e.kind);
            end
            check({kname(m_e.kind), ".err"}, int'(err), m_e.err);
            check({kname(m_e.kind), ".beat_cnt"}, int'(beat_cnt), m_e.cnt);
            if (m_e.kind != KBad) begin
              if (m_e.n_req >= 0)  check({kname(m_e.kind), ".req_cycles"}, a_req, m_e.n_req);
              if (m_e.n_beat >= 0) check({kname(m_e.kind), ".beats"}, a_beat, m_e.n_beat);
              if (m_e.n_busy >= 0) check({kname(m_e.kind), ".busy_cycles"}, a_busy, m_e.n_busy);
              check({kname(m_e.kind), ".dly_cycles"}, a_dly, m_e.n_dly);
              check({kname(m_e.kind), ".done_pulses"}, a_done, m_e.n_done);
              if (m_e.done_off >= 0) check({kname(m_e.kind), ".done_cycle"}, a_off, m_e.done_off);
            end
          end
        end
      end
      prev_busy = busy;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers. Inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  function automatic bit rb();
    return 1'($urandom_range(1));
  endfunction

  task automatic drive(input bit s, input int l, input bit g, input bit r, input bit h);
    start    = s;
    len      = LEN_W'(l);
    gnt      = g;
    tgt_rdy  = r;
    tgt_hold = h;
    @(posedge clk);
    #1;
  endtask

  // Busy cycles carry stray start strobes that the requester must ignore.
  task automatic busy_cycle(input bit g, input bit r, input bit h);
    drive(($urandom_range(3) == 0), int'($urandom_range(255)), g, r, h);
  endtask

  task automatic idle_gap(input int n);
    repeat (n) drive(1'b0, 0, 1'b0, rb(), rb());
  endtask

  // One command. g = cycles the arbiter waits after req before granting
  // (g >= TIMEOUT means never); mode selects the target ready pattern;
  // loss_k > 0 drops the grant right after that many beats; h = hold cycles.
  task automatic run_txn(input int l, input int g, input int mode, input int loss_k,
                         input int h, input int gap);
    bit   rdy_q[$];
    int   beats;
    int   target;
    int   nx;
    int   n_req;
    bit   r;
    exp_t e;

    if (g >= int'(TIMEOUT)) begin
      e = '{KTmo, 0, TIMEOUT, 0, 0, TIMEOUT, 0, -1, 1};
      exp_q.push_back(e);
      last_cnt = 0;
      drive(1'b1, l, 1'b0, rb(), rb());
      repeat (TIMEOUT) busy_cycle(1'b0, rb(), rb());
    end else begin
      // Beats land on granted cycles where the target is ready.
      beats  = 0;
      target = (loss_k > 0) ? loss_k : l;
      while (beats < target) begin
        case (mode)
          0:       r = 1'b1;
          1:       r = (rdy_q.size() % 2 == 0);
          2:       r = ($urandom_range(2) != 0);
          default: r = ($urandom_range(3) == 0);
        endcase
        rdy_q.push_back(r);
        beats += int'(r);
      end
      nx    = rdy_q.size() + ((loss_k > 0) ? 1 : 0);
      n_req = g + 1 + nx;
      if (loss_k > 0) begin
        e = '{KLoss, loss_k, n_req, loss_k, 0, n_req, 0, -1, 1};
        last_cnt = loss_k;
      end else begin
        e = '{KSucc, l, n_req, l, h, n_req + 1 + h, 1, n_req, 0};
        last_cnt = l;
      end
      exp_q.push_back(e);

      drive(1'b1, l, 1'b0, rb(), rb());
      repeat (g) busy_cycle(1'b0, rb(), rb());
      busy_cycle(1'b1, rb(), rb());
      foreach (rdy_q[i]) busy_cycle(1'b1, rdy_q[i], rb());
      if (loss_k > 0) begin
        busy_cycle(1'b0, rb(), rb());
      end else begin
        busy_cycle(1'b1, rb(), (h > 0));
        if (h > 0) begin
          repeat (h - 1) busy_cycle(1'b0, rb(), 1'b1);
          busy_cycle(1'b0, rb(), 1'b0);
        end
      end
    end
    idle_gap(gap);
  endtask

  task automatic run_bad(input int gap);
    exp_t e;
    e = '{KBad, last_cnt, -1, -1, 0, -1, 0, -1, 1};
    exp_q.push_back(e);
    drive(1'b1, 0, 1'b0, rb(), rb());
    idle_gap(gap);
  endtask

  // Reset lands in the first XFER cycle while a beat is being offered.
  task automatic run_rst(input int l);
    exp_t e;
    e = '{KRst, 0, -1, -1, 0, -1, 0, -1, 0};
    exp_q.push_back(e);
    last_cnt = 0;
    drive(1'b1, l, 1'b0, 1'b1, 1'b0);
    busy_cycle(1'b0, 1'b1, 1'b0);
    busy_cycle(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    busy_cycle(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    idle_gap(2);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int sel, l, k;
    rst      = 1'b1;
    start    = 1'b1;
    len      = LEN_W'(5);
    gnt      = 1'b1;
    tgt_rdy  = 1'b1;
    tgt_hold = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.req", int'(req), 0);
    check("reset.done", int'(done), 0);
    check("reset.dly", int'(dly), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.beat", int'(beat), 0);
    check("reset.err", int'(err), 0);
    check("reset.beat_cnt", int'(beat_cnt), 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    idle_gap(2);

    run_txn(4, 1, 0, 0, 0, 2);              // basic: done at cycle 7
    run_txn(3, 1, 1, 0, 3, 1);              // stalls 1,0,1,0,1 and 3 hold cycles
    run_txn(5, TIMEOUT + 3, 0, 0, 0, 1);    // grant never arrives
    run_txn(2, TIMEOUT - 1, 0, 0, 0, 0);    // grant on the timeout edge wins
    run_txn(8, 1, 0, 5, 0, 1);              // grant lost after beat 5
    run_bad(0);                             // len = 0
    run_bad(1);
    run_rst(8);
    run_txn(1, 1, 0, 0, 0, 0);              // back-to-back singles
    run_txn(1, 1, 0, 0, 0, 1);
    run_txn((1 << LEN_W) - 1, 0, 0, 0, 1, 1);  // full-range length

    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(9));
      if (sel == 0) begin
        run_bad(int'($urandom_range(2)));
      end else if (sel == 1) begin
        run_txn(int'($urandom_range(1, 20)), int'(TIMEOUT) + int'($urandom_range(4)), 0, 0, 0,
                int'($urandom_range(2)));
      end else if (sel == 2) begin
        l = int'($urandom_range(2, 20));
        k = int'($urandom_range(1, l - 1));
        run_txn(l, int'($urandom_range(TIMEOUT - 1)), int'($urandom_range(3)), k, 0,
                int'($urandom_range(2)));
      end else begin
        run_txn(int'($urandom_range(1, 30)), int'($urandom_range(TIMEOUT - 1)),
                int'($urandom_range(3)), 0, int'($urandom_range(4)), int'($urandom_range(2)));
      end
    end

    idle_gap(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
